// File: rtl/pe_result_collector_pkg.sv
// ---------------------------------------------------------------------------
// pe_result_collector_pkg
// Shared definitions for the PE result collector slice: FSM state encoding,
// default word width, capture-timer width and an index-width helper.
// ---------------------------------------------------------------------------
package pe_result_collector_pkg;

    // Width of one PE result word unless the instantiating level overrides it.
    localparam int DEFAULT_DATA_WIDTH = 16;

    // CAPTURE_LAT tops out at 15, so four bits always hold the countdown.
    localparam int LAT_WIDTH = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_DRAIN = 2'd2
    } state_e;

    // Bits needed to address numEntries buffer slots, never less than one.
    function automatic int idxWidth(input int numEntries);
        return (numEntries > 1) ? $clog2(numEntries) : 1;
    endfunction

endpackage

// File: rtl/pe_result_collector_if.sv
// ---------------------------------------------------------------------------
// pe_result_collector_if
// Valid/ready result stream from the collector to the writeback logic.
//   o_data  : current result word
//   o_valid : o_data holds a word
//   o_last  : current word belongs to the last PE of the row
//   i_ready : writeback accepts the word on this edge
// The master modport is the collector; the slave modport is the consumer.
// ---------------------------------------------------------------------------
interface pe_result_collector_if
    import pe_result_collector_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
);

    logic [DATA_WIDTH-1:0] o_data;
    logic                  o_valid;
    logic                  o_last;
    logic                  i_ready;

    modport master (
        output o_data,
        output o_valid,
        output o_last,
        input  i_ready
    );

    modport slave (
        input  o_data,
        input  o_valid,
        input  o_last,
        output i_ready
    );

endinterface

// File: rtl/pe_result_collector_timer.sv
// ---------------------------------------------------------------------------
// pe_capture_timer
// Loadable down-counter that times the capture edge after a finish pulse.
//   clk       : rising-edge clock
//   rst       : synchronous active-high reset
//   load_i    : reload the counter with CAPTURE_LAT on this edge
//   capture_o : high during the cycle whose closing edge is the capture edge
// ---------------------------------------------------------------------------
module pe_capture_timer
    import pe_result_collector_pkg::*;
#(
    parameter int CAPTURE_LAT = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic load_i,
    output logic capture_o
);

    logic [LAT_WIDTH-1:0] count_q;

    // Load on an accepted finish, then count down to zero and park there.
    // A count of one means the next edge is the capture edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else if (load_i) begin
            count_q <= LAT_WIDTH'(CAPTURE_LAT);
        end else if (count_q != '0) begin
            count_q <= count_q - 1'b1;
        end
    end

    assign capture_o = (count_q == LAT_WIDTH'(1));

endmodule

// File: rtl/pe_result_collector.sv
// ---------------------------------------------------------------------------
// pe_result_collector
// Snapshots a row of PE results a fixed delay after the broadcast finish
// strobe and streams them out one word per transfer, PE 0 first.
//   clk       : rising-edge clock
//   rst       : synchronous active-high reset
//   finish    : accumulation-done strobe shared with the PE row
//   i_result  : concatenated PE results, PE k at [k*DATA_WIDTH +: DATA_WIDTH]
//   stream    : valid/ready result stream (master side)
//   o_busy    : collector is waiting for capture or draining
//   o_overrun : sticky flag, a finish request was dropped
// ---------------------------------------------------------------------------
module pe_result_collector
    import pe_result_collector_pkg::*;
#(
    parameter int DATA_WIDTH  = DEFAULT_DATA_WIDTH,
    parameter int NUM_PE      = 4,
    parameter int CAPTURE_LAT = 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         finish,
    input  logic [NUM_PE*DATA_WIDTH-1:0] i_result,
    pe_result_collector_if.master        stream,
    output logic                         o_busy,
    output logic                         o_overrun
);

    localparam int IDX_W = idxWidth(NUM_PE);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_PE - 1);

    state_e                state_q;
    logic [DATA_WIDTH-1:0] buffer_q [NUM_PE];
    logic [IDX_W-1:0]      index_q;
    logic [DATA_WIDTH-1:0] data_q;
    logic                  last_q;
    logic                  overrun_q;

    logic                  finalXfer;
    logic                  acceptFinish;
    logic                  capture;
    logic [IDX_W-1:0]      nextIndex;

    // A finish is taken when idle, or when it coincides with the final
    // transfer of a drain so back-to-back bursts need no idle gap.
    assign finalXfer    = (state_q == ST_DRAIN) && last_q && stream.i_ready;
    assign acceptFinish = finish && ((state_q == ST_IDLE) || finalXfer);
    assign nextIndex    = index_q + 1'b1;

    pe_capture_timer #(
        .CAPTURE_LAT (CAPTURE_LAT)
    ) u_timer (
        .clk       (clk),
        .rst       (rst),
        .load_i    (acceptFinish),
        .capture_o (capture)
    );

    // Collector FSM. The outgoing word and its last flag are registered
    // here so the stream never depends combinationally on i_ready or finish;
    // on each transfer the following buffer slot is preloaded into data_q.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            index_q   <= '0;
            data_q    <= '0;
            last_q    <= 1'b0;
            overrun_q <= 1'b0;
            for (int k = 0; k < NUM_PE; k++) begin
                buffer_q[k] <= '0;
            end
        end else begin
            if (finish && !acceptFinish) begin
                overrun_q <= 1'b1;
            end
            case (state_q)
                ST_IDLE: begin
                    if (finish) begin
                        state_q <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (capture) begin
                        for (int k = 0; k < NUM_PE; k++) begin
                            buffer_q[k] <= i_result[k*DATA_WIDTH +: DATA_WIDTH];
                        end
                        index_q <= '0;
                        data_q  <= i_result[DATA_WIDTH-1:0];
                        last_q  <= 1'b0;
                        state_q <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (stream.i_ready) begin
                        if (last_q) begin
                            index_q <= '0;
                            last_q  <= 1'b0;
                            state_q <= finish ? ST_WAIT : ST_IDLE;
                        end else begin
                            index_q <= nextIndex;
                            data_q  <= buffer_q[nextIndex];
                            last_q  <= (nextIndex == LAST_IDX);
                        end
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign stream.o_data  = data_q;
    assign stream.o_valid = (state_q == ST_DRAIN);
    assign stream.o_last  = last_q;
    assign o_busy         = (state_q != ST_IDLE);
    assign o_overrun      = overrun_q;

endmodule

// File: tb/tb_pe_result_collector.sv
// ---------------------------------------------------------------------------
// tb_pe_result_collector
// Drives two collectors (CAPTURE_LAT 1 and 3) with directed finish/ready
// sequences. A queue-level model predicts every output each cycle, and a set
// of literal expectations pins the burst contents and timing.
// ---------------------------------------------------------------------------
module tb_pe_result_collector;
    import pe_result_collector_pkg::*;

    localparam int DW  = 16;
    localparam int NPE = 4;
    localparam int LAT [2] = '{1, 3};

    logic clk = 1'b0;
    logic rst;
    logic fin [2];
    logic rdy [2];
    logic [NPE*DW-1:0] res [2];

    logic busy0, busy1, ovr0, ovr1;
    logic aValid [2];
    logic aLast  [2];
    logic aBusy  [2];
    logic aOvr   [2];
    logic [DW-1:0] aData [2];

    int compared   = 0;
    int mismatched = 0;

    // Model state: words still to send, the captured words, capture countdown
    int            mCount  [2];
    int            mCapCnt [2];
    bit            mOvr    [2];
    logic [DW-1:0] mWords  [2][NPE];

    logic [DW-1:0] got0 [$];
    logic [DW-1:0] got1 [$];

    always #5 clk = ~clk;

    pe_result_collector_if #(.DATA_WIDTH(DW)) bus0 ();
    pe_result_collector_if #(.DATA_WIDTH(DW)) bus1 ();

    assign bus0.i_ready = rdy[0];
    assign bus1.i_ready = rdy[1];

    pe_result_collector #(.DATA_WIDTH(DW), .NUM_PE(NPE), .CAPTURE_LAT(1)) dut0 (
        .clk       (clk),
        .rst       (rst),
        .finish    (fin[0]),
        .i_result  (res[0]),
        .stream    (bus0.master),
        .o_busy    (busy0),
        .o_overrun (ovr0)
    );

    pe_result_collector #(.DATA_WIDTH(DW), .NUM_PE(NPE), .CAPTURE_LAT(3)) dut1 (
        .clk       (clk),
        .rst       (rst),
        .finish    (fin[1]),
        .i_result  (res[1]),
        .stream    (bus1.master),
        .o_busy    (busy1),
        .o_overrun (ovr1)
    );

    assign aValid[0] = bus0.o_valid;
    assign aValid[1] = bus1.o_valid;
    assign aLast[0]  = bus0.o_last;
    assign aLast[1]  = bus1.o_last;
    assign aData[0]  = bus0.o_data;
    assign aData[1]  = bus1.o_data;
    assign aBusy[0]  = busy0;
    assign aBusy[1]  = busy1;
    assign aOvr[0]   = ovr0;
    assign aOvr[1]   = ovr1;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // One clock edge's worth of behaviour: a transfer consumes a word, an
    // expiring countdown snapshots the row, and finish is either taken
    // (idle, or on the final transfer) or recorded as an overrun.
    task automatic modelStep(input int u);
        bit wasBusy;
        bit finalX;
        if (rst) begin
            mCount[u]  = 0;
            mCapCnt[u] = 0;
            mOvr[u]    = 1'b0;
            return;
        end
        wasBusy = (mCapCnt[u] > 0) || (mCount[u] > 0);
        finalX  = 1'b0;
        if (mCount[u] > 0 && rdy[u]) begin
            finalX = (mCount[u] == 1);
            mCount[u]--;
        end
        if (mCapCnt[u] > 0) begin
            mCapCnt[u]--;
            if (mCapCnt[u] == 0) begin
                for (int k = 0; k < NPE; k++) begin
                    mWords[u][k] = res[u][k*DW +: DW];
                end
                mCount[u] = NPE;
            end
        end
        if (fin[u]) begin
            if (!wasBusy || finalX) mCapCnt[u] = LAT[u];
            else                    mOvr[u] = 1'b1;
        end
    endtask

    // At each edge: log the word actually handed over, advance the model,
    // then compare every output of both collectors just after the edge.
    always @(posedge clk) begin
        if (!rst && aValid[0] === 1'b1 && rdy[0]) got0.push_back(aData[0]);
        if (!rst && aValid[1] === 1'b1 && rdy[1]) got1.push_back(aData[1]);
        modelStep(0);
        modelStep(1);
        #1;
        for (int u = 0; u < 2; u++) begin
            checkOutput($sformatf("u%0d valid", u), aValid[u], mCount[u] > 0);
            checkOutput($sformatf("u%0d last", u), aLast[u], mCount[u] == 1);
            checkOutput($sformatf("u%0d busy", u), aBusy[u], (mCount[u] > 0) || (mCapCnt[u] > 0));
            checkOutput($sformatf("u%0d overrun", u), aOvr[u], mOvr[u]);
            if (mCount[u] > 0) begin
                checkOutput($sformatf("u%0d data", u), aData[u], mWords[u][NPE - mCount[u]]);
            end
        end
    end

    task automatic applyStimulus(input int u, input bit f, input bit r, input bit rs);
        fin[u] = f;
        rdy[u] = r;
        rst    = rs;
        @(posedge clk);
        #2;
        fin[u] = 1'b0;
        rst    = 1'b0;
    endtask

    function automatic logic [DW-1:0] gotWord(input int u, input int i);
        if (u == 0) return (i < got0.size()) ? got0[i] : 'x;
        return (i < got1.size()) ? got1[i] : 'x;
    endfunction

    task automatic checkBurst(input string name, input int u, input int offset,
                              input logic [DW-1:0] w0, input logic [DW-1:0] w1,
                              input logic [DW-1:0] w2, input logic [DW-1:0] w3);
        checkOutput({name, " w0"}, gotWord(u, offset + 0), w0);
        checkOutput({name, " w1"}, gotWord(u, offset + 1), w1);
        checkOutput({name, " w2"}, gotWord(u, offset + 2), w2);
        checkOutput({name, " w3"}, gotWord(u, offset + 3), w3);
    endtask

    // Directed scenarios, each with literal expectations on top of the model.
    initial begin
        fin = '{1'b0, 1'b0};
        rdy = '{1'b0, 1'b0};
        res = '{'0, '0};
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b0;

        checkOutput("reset valid", bus0.o_valid, 0);
        checkOutput("reset data", bus0.o_data, 0);
        checkOutput("reset busy", busy0, 0);
        checkOutput("reset overrun", ovr0, 0);

        // Basic drain at full rate
        $display("[TB] basic drain");
        res[0] = {16'd40, 16'd30, 16'd20, 16'd2000};
        got0.delete();
        applyStimulus(0, 1, 1, 0);
        checkOutput("basic wait valid", bus0.o_valid, 0);
        checkOutput("basic wait busy", busy0, 1);
        applyStimulus(0, 0, 1, 0);
        checkOutput("basic first valid", bus0.o_valid, 1);
        checkOutput("basic first data", bus0.o_data, 16'd2000);
        checkOutput("basic first last", bus0.o_last, 0);
        repeat (3) applyStimulus(0, 0, 1, 0);
        checkOutput("basic last flag", bus0.o_last, 1);
        checkOutput("basic last data", bus0.o_data, 16'd40);
        applyStimulus(0, 0, 1, 0);
        checkOutput("basic done busy", busy0, 0);
        checkOutput("basic count", got0.size(), 4);
        checkBurst("basic", 0, 0, 16'd2000, 16'd20, 16'd30, 16'd40);

        // Backpressure on the first word
        $display("[TB] backpressure");
        got0.delete();
        applyStimulus(0, 1, 1, 0);
        applyStimulus(0, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(0, 0, 0, 0);
            checkOutput("stall data", bus0.o_data, 16'd2000);
        end
        repeat (4) applyStimulus(0, 0, 1, 0);
        checkOutput("stall done busy", busy0, 0);
        checkOutput("stall count", got0.size(), 4);
        checkBurst("stall", 0, 0, 16'd2000, 16'd20, 16'd30, 16'd40);

        // finish in mid-drain is dropped and flagged
        $display("[TB] overrun");
        got0.delete();
        applyStimulus(0, 1, 1, 0);
        applyStimulus(0, 0, 1, 0);
        applyStimulus(0, 0, 1, 0);
        applyStimulus(0, 1, 1, 0);
        checkOutput("overrun set", ovr0, 1);
        repeat (6) applyStimulus(0, 0, 1, 0);
        checkOutput("overrun sticky", ovr0, 1);
        checkOutput("overrun count", got0.size(), 4);

        // Reset in the middle of a stalled drain
        $display("[TB] reset mid-drain");
        applyStimulus(0, 1, 1, 0);
        applyStimulus(0, 0, 0, 0);
        applyStimulus(0, 0, 0, 1);
        checkOutput("rst valid", bus0.o_valid, 0);
        checkOutput("rst data", bus0.o_data, 0);
        checkOutput("rst last", bus0.o_last, 0);
        checkOutput("rst busy", busy0, 0);
        checkOutput("rst overrun", ovr0, 0);
        got0.delete();
        applyStimulus(0, 1, 1, 0);
        checkOutput("post-rst busy", busy0, 1);
        repeat (5) applyStimulus(0, 0, 1, 0);
        checkOutput("post-rst overrun", ovr0, 0);
        checkBurst("post-rst", 0, 0, 16'd2000, 16'd20, 16'd30, 16'd40);

        // Back-to-back bursts: finish lands on the final transfer
        $display("[TB] back-to-back");
        got0.delete();
        applyStimulus(0, 1, 1, 0);
        applyStimulus(0, 0, 1, 0);
        repeat (3) applyStimulus(0, 0, 1, 0);
        res[0] = {16'd4, 16'd3, 16'd2, 16'd1};
        applyStimulus(0, 1, 1, 0);
        checkOutput("b2b overrun", ovr0, 0);
        checkOutput("b2b gap valid", bus0.o_valid, 0);
        checkOutput("b2b busy", busy0, 1);
        applyStimulus(0, 0, 1, 0);
        checkOutput("b2b second first", bus0.o_data, 16'd1);
        repeat (4) applyStimulus(0, 0, 1, 0);
        checkOutput("b2b count", got0.size(), 8);
        checkOutput("b2b done busy", busy0, 0);
        checkBurst("b2b first", 0, 0, 16'd2000, 16'd20, 16'd30, 16'd40);
        checkBurst("b2b second", 0, 4, 16'd1, 16'd2, 16'd3, 16'd4);

        // CAPTURE_LAT=3: the row changes right before the capture edge
        $display("[TB] capture latency 3");
        res[1] = {16'hA3, 16'hA2, 16'hA1, 16'hA0};
        got1.delete();
        applyStimulus(1, 1, 1, 0);
        applyStimulus(1, 0, 1, 0);
        applyStimulus(1, 0, 1, 0);
        checkOutput("lat3 pre-capture valid", bus1.o_valid, 0);
        checkOutput("lat3 pre-capture busy", busy1, 1);
        res[1] = {16'hB3, 16'hB2, 16'hB1, 16'hB0};
        applyStimulus(1, 0, 1, 0);
        checkOutput("lat3 capture valid", bus1.o_valid, 1);
        checkOutput("lat3 capture data", bus1.o_data, 16'hB0);
        res[1] = {16'hA3, 16'hA2, 16'hA1, 16'hA0};
        repeat (4) applyStimulus(1, 0, 1, 0);
        checkOutput("lat3 done busy", busy1, 0);
        checkOutput("lat3 count", got1.size(), 4);
        checkBurst("lat3", 1, 0, 16'hB0, 16'hB1, 16'hB2, 16'hB3);

        repeat (2) @(posedge clk);
        #2;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
